mux2to1_stream_arb: RTL

//  Merges two valid/ready source streams onto one output stream using round-robin arbitration.

---
 rtl/mux_arb_pkg.sv | 15 +
 rtl/mux2to1_stream_arb_rr_arb2.sv | 44 ++++
 rtl/mux2to1_stream_arb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 2:1 stream merge arbiter.
package mux_arb_pkg;

  // Arbitration state: free to arbitrate, or locked to one source mid-packet.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  // Source indices as carried on out_sel (drives the far-end demux select).
  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/mux2to1_stream_arb_rr_arb2.sv
// Two-requester round-robin arbiter. Owns the priority flop; a lock input
// pins the grant to lock_id regardless of the request vector.
module rr_arb2
  import mux_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       lock_id,
  input  logic       advance,
  output logic       gnt_id,
  output logic       gnt_vld
);

  logic r_prio;

  // Priority flop: after a completed grant the other source is preferred next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= SEL_IN0;
    end else if (advance) begin
      r_prio <= ~gnt_id;
    end
  end

  // Grant selection: lock wins, otherwise single requester or priority on contention.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = r_prio;
    if (lock) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id;
    end else begin
      case (req)
        2'b01:   begin gnt_vld = 1'b1; gnt_id = SEL_IN0; end
        2'b10:   begin gnt_vld = 1'b1; gnt_id = SEL_IN1; end
        2'b11:   begin gnt_vld = 1'b1; gnt_id = r_prio;  end
        default: begin gnt_vld = 1'b0; gnt_id = r_prio;  end
      endcase
    end
  end

endmodule

// File: rtl/mux2to1_stream_arb.sv
// Merges two valid/ready source streams into one registered output stream.
// Handshake: on every interface a beat transfers on a clock edge where
// valid && ready; sources hold data/last while valid && !ready, inN_ready may
// depend on inN_valid, and out_valid never depends on out_ready.
// With PKT_MODE=1 the grant stays on one source until its last beat is accepted.
module mux2to1_stream_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PKT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_sel,
  input  logic             out_ready,
  output arb_state_t       o_dbg_state
);

  localparam bit LP_PKT = (PKT_MODE != 0);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_out_sel;

  logic w_can_load;
  logic w_gnt_id;
  logic w_gnt_vld;
  logic w_lock;
  logic w_lock_id;
  logic w_acc0;
  logic w_acc1;
  logic w_acc;
  logic w_acc_id;
  logic w_acc_last;
  logic w_advance;

  // Output register can take a new beat when empty or being drained this cycle.
  assign w_can_load = !r_out_valid || out_ready;

  // Readies are forced low while reset is asserted.
  assign in0_ready = rst_n && w_can_load && w_gnt_vld && (w_gnt_id == SEL_IN0);
  assign in1_ready = rst_n && w_can_load && w_gnt_vld && (w_gnt_id == SEL_IN1);

  assign w_acc0     = in0_valid && in0_ready;
  assign w_acc1     = in1_valid && in1_ready;
  assign w_acc      = w_acc0 || w_acc1;
  assign w_acc_id   = w_acc1 ? SEL_IN1 : SEL_IN0;
  assign w_acc_last = w_acc1 ? in1_last : in0_last;

  // Priority moves on whenever an arbitration round completes.
  assign w_advance = w_acc && (!LP_PKT || w_acc_last);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({in1_valid, in0_valid}),
    .lock    (w_lock),
    .lock_id (w_lock_id),
    .advance (w_advance),
    .gnt_id  (w_gnt_id),
    .gnt_vld (w_gnt_vld)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: lock on a non-last beat in packet mode, unlock on last.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (LP_PKT && w_acc && !w_acc_last) begin
          w_state_nxt = (w_acc_id == SEL_IN1) ? ARB_LOCK1 : ARB_LOCK0;
        end
      end
      ARB_LOCK0, ARB_LOCK1: begin
        if (w_acc && w_acc_last) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // FSM outputs: lock request and locked source index for the arbiter.
  always_comb begin
    w_lock    = 1'b0;
    w_lock_id = SEL_IN0;
    case (r_state)
      ARB_LOCK0: begin w_lock = 1'b1; w_lock_id = SEL_IN0; end
      ARB_LOCK1: begin w_lock = 1'b1; w_lock_id = SEL_IN1; end
      default:   begin w_lock = 1'b0; w_lock_id = SEL_IN0; end
    endcase
  end

  // One-entry output register; holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= SEL_IN0;
    end else if (w_can_load) begin
      r_out_valid <= w_acc;
      if (w_acc) begin
        r_out_data <= w_acc1 ? in1_data : in0_data;
        r_out_last <= w_acc_last;
        r_out_sel  <= w_acc_id;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_sel     = r_out_sel;
  assign o_dbg_state = r_state;

endmodule
